// File: rtl/serial_pattern_gen.sv
// Serial pattern transmitter: latches a pattern word on start and shifts it out
// MSB-first, one bit per en strobe, repeating with an optional idle gap.
module serial_pattern_gen #(
  parameter int w   = 10,
  parameter int lw  = 4,
  parameter int rw  = 4,
  parameter int gap = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          start,
  input  logic          stop,
  input  logic [w-1:0]  pattern,
  input  logic [lw-1:0] len,
  input  logic [rw-1:0] repeats,
  output logic          ready,
  output logic          bit_out,
  output logic          bit_valid,
  output logic          last,
  output logic          done,
  output logic [rw-1:0] rep_cnt
);

  localparam int            gw    = (gap > 1) ? $clog2(gap + 1) : 1;
  localparam logic [lw-1:0] w_l   = lw'(w);
  localparam logic [gw-1:0] gap_l = gw'(gap);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t        state, state_n;
  logic [w-1:0]  pat_r, pat_n;
  logic [lw-1:0] len_r, len_n;
  logic [rw-1:0] rpt_r, rpt_n;
  logic [lw-1:0] idx, idx_n;
  logic [gw-1:0] gcnt, gcnt_n;
  logic [rw-1:0] rep_n;
  logic          done_n;

  logic [lw-1:0] len_clamp;
  logic [lw-1:0] sel;
  logic [w-1:0]  pat_sh;
  logic [rw-1:0] rep_inc;
  logic [gw-1:0] gcnt_inc;
  logic          idx_end;

  // a zero or oversize length means "send the whole word"
  assign len_clamp = (len == '0 || len > w_l) ? w_l : len;
  assign idx_end   = (idx == len_r - 1'b1);
  assign rep_inc   = rep_cnt + 1'b1;
  assign gcnt_inc  = gcnt + 1'b1;
  assign sel       = len_r - 1'b1 - idx;
  assign pat_sh    = pat_r >> sel;

  // next-state logic: stop wins over everything, en=0 holds all state
  always_comb begin
    state_n = state;
    pat_n   = pat_r;
    len_n   = len_r;
    rpt_n   = rpt_r;
    idx_n   = idx;
    gcnt_n  = gcnt;
    rep_n   = rep_cnt;
    done_n  = 1'b0;
    if (stop) begin
      state_n = IDLE;
      idx_n   = '0;
      gcnt_n  = '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pat_n   = pattern;
          len_n   = len_clamp;
          rpt_n   = repeats;
          idx_n   = '0;
          gcnt_n  = '0;
          rep_n   = '0;
          state_n = SEND;
        end
        SEND: if (en) begin
          if (!idx_end) begin
            idx_n = idx + 1'b1;
          end else begin
            rep_n = rep_inc;
            if (rpt_r != '0 && rep_inc == rpt_r) begin
              state_n = IDLE;
              done_n  = 1'b1;
              idx_n   = '0;
            end else if (gap > 0) begin
              state_n = GAP;
              gcnt_n  = '0;
            end else begin
              idx_n = '0;
            end
          end
        end
        GAP: if (en) begin
          if (gcnt_inc == gap_l) begin
            state_n = SEND;
            idx_n   = '0;
            gcnt_n  = '0;
          end else begin
            gcnt_n = gcnt_inc;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // register update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pat_r   <= '0;
      len_r   <= '0;
      rpt_r   <= '0;
      idx     <= '0;
      gcnt    <= '0;
      rep_cnt <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      pat_r   <= pat_n;
      len_r   <= len_n;
      rpt_r   <= rpt_n;
      idx     <= idx_n;
      gcnt    <= gcnt_n;
      rep_cnt <= rep_n;
      done    <= done_n;
    end
  end

  // outputs decoded from registered state
  always_comb begin
    ready     = (state == IDLE);
    bit_valid = (state == SEND);
    bit_out   = bit_valid & pat_sh[0];
    last      = (state == SEND) && idx_end && (rpt_r != '0) &&
                (rep_cnt == rpt_r - 1'b1);
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Self-checking bench for serial_pattern_gen: table of runs, scoreboard queue
// of expected serial items, plus hand-written corner sequences.
module tb_serial_pattern_gen;

  logic       clk = 1'b0;
  logic       reset, en, start, stop;
  logic [9:0] pattern;
  logic [3:0] len, repeats;
  logic       ready, bit_out, bit_valid, last, done;
  logic [3:0] rep_cnt;

  int checks = 0;
  int failures = 0;

  serial_pattern_gen #(.w(10), .lw(4), .rw(4), .gap(2)) dut (
    .clk(clk), .reset(reset), .en(en), .start(start), .stop(stop),
    .pattern(pattern), .len(len), .repeats(repeats),
    .ready(ready), .bit_out(bit_out), .bit_valid(bit_valid), .last(last),
    .done(done), .rep_cnt(rep_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] pat;
    logic [3:0] len;
    logic [3:0] rpt;
    int         per;      // clocks per en strobe
    int         mid;      // strobe index carrying a stray start (-1 none)
    int         exp_len;  // expected bits per repetition
    int         total;    // expected strobes for the whole run
  } cfg_t;

  typedef struct {
    logic v;
    logic b;
    logic l;
    int   rc;
  } item_t;

  item_t q[$];
  cfg_t  tbl[5];
  cfg_t  cb, cc;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_item(input string nm, input item_t it);
    chk({nm, ".bit_valid"}, bit_valid, it.v);
    chk({nm, ".bit_out"}, bit_out, it.b);
    chk({nm, ".last"}, last, it.l);
    chk({nm, ".rep_cnt"}, rep_cnt, it.rc);
    chk({nm, ".done"}, done, 0);
  endtask

  // build expected stream, start the run, pop and compare on every strobe;
  // returns at the negedge after the final strobe (the done cycle if finite)
  task automatic run(input string nm, input cfg_t c);
    item_t it;
    int r;
    bit fin;
    fin = (c.rpt != 0);
    q.delete();
    r = 0;
    while (q.size() < c.total + 1) begin
      for (int k = 0; k < c.exp_len; k++) begin
        it.v  = 1'b1;
        it.b  = c.pat[c.exp_len - 1 - k];
        it.l  = fin && (r == c.rpt - 1) && (k == c.exp_len - 1);
        it.rc = r % 16;
        q.push_back(it);
      end
      if (fin && r == c.rpt - 1) break;
      for (int g = 0; g < 2; g++) begin
        it.v = 1'b0; it.b = 1'b0; it.l = 1'b0; it.rc = (r + 1) % 16;
        q.push_back(it);
      end
      r++;
    end
    pattern = c.pat; len = c.len; repeats = c.rpt; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, ".ready_busy"}, ready, 0);
    for (int i = 0; i < c.total; i++) begin
      it = q.pop_front();
      for (int h = 1; h < c.per; h++) begin
        chk_item({nm, ".hold"}, it);
        @(negedge clk);
      end
      chk_item(nm, it);
      en = 1'b1;
      if (i == c.mid) begin
        start = 1'b1; pattern = ~c.pat; len = 4'd2;
      end
      @(negedge clk);
      en = 1'b0; start = 1'b0;
    end
    if (fin) begin
      chk({nm, ".done"}, done, 1);
      chk({nm, ".done_ready"}, ready, 1);
      chk({nm, ".done_valid"}, bit_valid, 0);
      chk({nm, ".final_rep_cnt"}, rep_cnt, c.rpt);
    end else begin
      chk_item({nm, ".cont_next"}, q[0]);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0;
    pattern = '0; len = '0; repeats = '0;
    tbl[0] = '{10'b0000001011, 4'd4,  4'd1, 2, -1, 4,  4};
    tbl[1] = '{10'b0000001011, 4'd4,  4'd3, 1, -1, 4,  16};
    tbl[2] = '{10'b1100110011, 4'd0,  4'd1, 1, -1, 10, 10};
    tbl[3] = '{10'b1100110011, 4'd15, 4'd2, 3, 5,  10, 22};
    tbl[4] = '{10'b0000000101, 4'd3,  4'd2, 1, -1, 3,  8};
    cb = '{10'b0000000110, 4'd3, 4'd1, 1, -1, 3, 3};
    cc = '{10'b0000000101, 4'd3, 4'd0, 1, -1, 3, 50};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst.ready", ready, 1);
    chk("rst.bit_valid", bit_valid, 0);
    chk("rst.bit_out", bit_out, 0);
    chk("rst.last", last, 0);
    chk("rst.done", done, 0);
    chk("rst.rep_cnt", rep_cnt, 0);

    // idle with en toggling every 4 clocks
    for (int i = 0; i < 16; i++) begin
      en = ((i / 4) % 2 == 1);
      @(negedge clk);
      chk("idle.ready", ready, 1);
      chk("idle.bit_valid", bit_valid, 0);
      chk("idle.bit_out", bit_out, 0);
      chk("idle.done", done, 0);
      chk("idle.rep_cnt", rep_cnt, 0);
    end
    en = 1'b0;

    // table-driven runs
    for (int t = 0; t < 5; t++) begin
      run($sformatf("tbl%0d", t), tbl[t]);
      @(negedge clk);
      chk($sformatf("tbl%0d.done_clear", t), done, 0);
      chk($sformatf("tbl%0d.idle_ready", t), ready, 1);
    end

    // start issued in the done cycle is accepted
    run("chainA", tbl[0]);
    run("chainB", cb);
    @(negedge clk);
    chk("chainB.done_clear", done, 0);

    // continuous run, then stop while a bit is being held
    run("cont", cc);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop.ready", ready, 1);
    chk("stop.bit_valid", bit_valid, 0);
    chk("stop.done", done, 0);
    chk("stop.rep_cnt", rep_cnt, 10);
    @(negedge clk);
    chk("stop.no_done", done, 0);

    // start and stop together in idle: no accept
    pattern = 10'b1111111111; len = 4'd4; repeats = 4'd1;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("ss.ready", ready, 1);
    chk("ss.bit_valid", bit_valid, 0);
    chk("ss.rep_cnt", rep_cnt, 10);

    // reset while in the gap
    pattern = 10'b0000001011; len = 4'd4; repeats = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; en = 1'b1;
    repeat (5) @(negedge clk);
    en = 1'b0;
    chk("gap.bit_valid", bit_valid, 0);
    chk("gap.ready", ready, 0);
    chk("gap.rep_cnt", rep_cnt, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("grst.ready", ready, 1);
    chk("grst.bit_valid", bit_valid, 0);
    chk("grst.bit_out", bit_out, 0);
    chk("grst.last", last, 0);
    chk("grst.done", done, 0);
    chk("grst.rep_cnt", rep_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
